// File: rtl/trap_pkg.sv
// trap_pkg: CSR addresses, trap cause codes and FSM states shared by the
// machine-mode trap sequencer.
package trap_pkg;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
    localparam logic [31:0] CAUSE_ECALL   = 32'd11;
    localparam logic [31:0] CAUSE_LFAULT  = 32'd5;
    localparam logic [31:0] CAUSE_SFAULT  = 32'd7;
    localparam logic [31:0] CAUSE_MEXT    = 32'h8000000B;

    localparam logic [1:0] WSC_WRITE = 2'b01;

    typedef enum logic [1:0] {IDLE, TRAP_W, TRAP_TV, RET} state_t;
endpackage

// File: rtl/trap_prio_enc.sv
// trap_prio_enc: picks the winning trap source and its mcause/mtval values.
// Exceptions outrank the external interrupt.
module trap_prio_enc
    import trap_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_valid,
    input  logic            i_exc_illegal,
    input  logic            i_exc_ecall,
    input  logic            i_exc_lfault,
    input  logic            i_exc_sfault,
    input  logic            i_ext_irq,
    input  logic            i_mie,
    input  logic [XLEN-1:0] i_inst,
    input  logic [XLEN-1:0] i_addr,
    output logic            o_take_trap,
    output logic [XLEN-1:0] o_cause,
    output logic [XLEN-1:0] o_tval
);
    logic w_exc;

    always_comb begin
        w_exc       = i_valid && (i_exc_illegal || i_exc_ecall || i_exc_lfault || i_exc_sfault);
        o_take_trap = w_exc || (i_ext_irq && i_mie);
        o_cause     = !w_exc        ? CAUSE_MEXT    :
                      i_exc_illegal ? CAUSE_ILLEGAL :
                      i_exc_ecall   ? CAUSE_ECALL   :
                      i_exc_lfault  ? CAUSE_LFAULT  : CAUSE_SFAULT;
        o_tval      = !w_exc        ? '0     :
                      i_exc_illegal ? i_inst :
                      i_exc_ecall   ? '0     : i_addr;
    end
endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer; writes mepc/mcause/mtval, pulses
// trap_begin/trap_end and redirects fetch to mtvec or mepc.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_valid_wb,
    input  logic [XLEN-1:0] i_pc_wb,
    input  logic [XLEN-1:0] i_inst_wb,
    input  logic [XLEN-1:0] i_addr_wb,
    input  logic            i_exc_illegal,
    input  logic            i_exc_ecall,
    input  logic            i_exc_lfault,
    input  logic            i_exc_sfault,
    input  logic            i_mret_wb,
    input  logic            i_ext_irq,
    input  logic [XLEN-1:0] i_mstatus,
    input  logic [XLEN-1:0] i_mtvec,
    input  logic [XLEN-1:0] i_mepc,
    output logic            o_csr_w,
    output logic            o_csr_w2,
    output logic [11:0]     o_waddr,
    output logic [11:0]     o_waddr2,
    output logic [XLEN-1:0] o_wdata,
    output logic [XLEN-1:0] o_wdata2,
    output logic [1:0]      o_csr_wsc_mode,
    output logic [1:0]      o_csr_wsc_mode2,
    output logic            o_trap_begin,
    output logic            o_trap_end,
    output logic            o_flush,
    output logic            o_stall,
    output logic            o_redirect,
    output logic [XLEN-1:0] o_redirect_pc
);
    state_t          r_state, w_next;
    logic [XLEN-1:0] r_pc, r_cause, r_tval;
    logic [XLEN-1:0] w_cause, w_tval;
    logic            w_take, w_ret, w_capture;

    trap_prio_enc #(.XLEN(XLEN)) u_prio (
        .i_valid      (i_valid_wb),
        .i_exc_illegal(i_exc_illegal),
        .i_exc_ecall  (i_exc_ecall),
        .i_exc_lfault (i_exc_lfault),
        .i_exc_sfault (i_exc_sfault),
        .i_ext_irq    (i_ext_irq),
        .i_mie        (i_mstatus[3]),
        .i_inst       (i_inst_wb),
        .i_addr       (i_addr_wb),
        .o_take_trap  (w_take),
        .o_cause      (w_cause),
        .o_tval       (w_tval)
    );

    assign w_ret = i_valid_wb && i_mret_wb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_pc    <= '0;
            r_cause <= '0;
            r_tval  <= '0;
        end else begin
            r_state <= w_next;
            if (w_capture) begin
                r_pc    <= i_pc_wb;
                r_cause <= w_cause;
                r_tval  <= w_tval;
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        w_capture     = 1'b0;
        o_csr_w       = 1'b0;
        o_csr_w2      = 1'b0;
        o_waddr       = '0;
        o_waddr2      = '0;
        o_wdata       = '0;
        o_wdata2      = '0;
        o_trap_begin  = 1'b0;
        o_trap_end    = 1'b0;
        o_redirect    = 1'b0;
        o_redirect_pc = '0;
        o_stall       = r_state != IDLE;
        o_flush       = r_state != IDLE;
        // Reset holds every output low, including the fixed write mode.
        o_csr_wsc_mode  = rst ? 2'b00 : WSC_WRITE;
        o_csr_wsc_mode2 = rst ? 2'b00 : WSC_WRITE;
        case (r_state)
            IDLE: begin
                w_capture = w_take;
                w_next    = w_take ? TRAP_W : w_ret ? RET : IDLE;
                o_flush   = !rst && (w_take || w_ret);
            end
            TRAP_W: begin
                w_next       = TRAP_TV;
                o_csr_w      = 1'b1;
                o_waddr      = CSR_MEPC;
                o_wdata      = r_pc;
                o_csr_w2     = 1'b1;
                o_waddr2     = CSR_MCAUSE;
                o_wdata2     = r_cause;
                o_trap_begin = 1'b1;
            end
            TRAP_TV: begin
                w_next        = IDLE;
                o_csr_w       = 1'b1;
                o_waddr       = CSR_MTVAL;
                o_wdata       = r_tval;
                o_redirect    = 1'b1;
                o_redirect_pc = {i_mtvec[XLEN-1:2], 2'b00};
            end
            default: begin
                w_next        = IDLE;
                o_trap_end    = 1'b1;
                o_redirect    = 1'b1;
                o_redirect_pc = i_mepc;
            end
        endcase
    end
endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Machine-mode trap sequencer driving the trap side of the CSR register file. It detects exceptions, external interrupts and `mret` at the write-back stage. It issues the CSR writes (mepc, mcause, mtval) over the CSR file's two write ports and pulses `trap_begin`/`trap_end` so the CSR file saves or restores MIE/MPIE. It flushes the pipeline and redirects fetch to mtvec or mepc.

## Interface
- `XLEN`, 32: data/address width.
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `valid_wb`  in  1  write-back slot holds a real instruction.
- `pc_wb`, `inst_wb`, `addr_wb`  in  32 each  PC, instruction word and memory address of the write-back instruction.
- `exc_illegal`, `exc_ecall`, `exc_lfault`, `exc_sfault`  in  1 each  exception flags for the write-back instruction.
- `mret_wb`  in  1  write-back instruction is `mret`.
- `ext_irq`  in  1  level external interrupt.
- `mstatus`, `mtvec`, `mepc`  in  32 each  live CSR values from the CSR file.
- `csr_w`, `csr_w2`  out  1 each  write enables for CSR ports 1 and 2.
- `waddr`, `waddr2`  out  12 each  CSR addresses for ports 1 and 2.
- `wdata`, `wdata2`  out  32 each  write data for ports 1 and 2.
- `csr_wsc_mode`, `csr_wsc_mode2`  out  2 each  always 2'b01 (plain write).
- `trap_begin`, `trap_end`  out  1 each  one-cycle pulses to the CSR file.
- `flush`  out  1  kill the write-back instruction and all younger instructions.
- `stall`  out  1  freeze the pipeline.
- `redirect`  out  1  fetch target strobe.
- `redirect_pc`  out  32  fetch target.

## Operation
- States: IDLE, TRAP_W, TRAP_TV, RET.
- Event qualification, IDLE only; the first match wins:
  1. Exception: `valid_wb` and any `exc_*` set.
  2. Interrupt: `ext_irq` and `mstatus[3]` (MIE) = 1.
  3. Return: `valid_wb` and `mret_wb`.
- Exception priority, highest first: illegal (cause 2) > ecall (11) > load fault (5) > store fault (7). Interrupt cause = 32'h8000000B.
- mtval by cause:
  - illegal: `inst_wb`.
  - load/store fault: `addr_wb`.
  - ecall and interrupt: 0.
- mepc by cause: `pc_wb` for every trap. An interrupted instruction is flushed and re-executes after `mret`.
- On a qualifying trap in IDLE: capture pc, cause and tval into internal registers; next state TRAP_W.
- TRAP_W:
  - Port 1 writes 0x341 (mepc) with the captured pc; port 2 writes 0x342 (mcause) with the captured cause.
  - `trap_begin` = 1.
  - Next state TRAP_TV.
- TRAP_TV:
  - Port 1 writes 0x343 (mtval) with the captured tval; port 2 idle.
  - `redirect` = 1, `redirect_pc` = {mtvec[31:2], 2'b00}. Direct mode only; mtvec[1:0] ignored.
  - Next state IDLE.
- On a qualifying return in IDLE: next state RET.
- RET:
  - `trap_end` = 1, `redirect` = 1, `redirect_pc` = `mepc` (live input).
  - Next state IDLE.
- Events seen while not in IDLE are ignored. The pipeline is stalled, so they stay presented and are re-evaluated in IDLE.

## Timing
- Event sampled at edge T (IDLE). `flush` is combinational and high in cycle T.
- Trap: TRAP_W in cycle T+1, TRAP_TV in T+2, IDLE in T+3. Total occupancy: 2 cycles after detection.
- Return: RET in T+1, IDLE in T+2.
- `stall` = (state != IDLE).
- `flush` = (qualifying event in IDLE) OR (state != IDLE).
- All outputs are Moore-decoded from the state and the captured registers, except the combinational `flush` term in IDLE.
- The CSR file sees mstatus updated at the end of T+1 (trap) or T+1 (return). An interrupt recheck in T+3 therefore sees MIE = 0.
- Reset: state IDLE; captured registers 0; every output 0, including `csr_wsc_mode`* (which read 2'b01 once out of reset). Reset mid-sequence aborts with no further writes or pulses.
- Simultaneous exception and `ext_irq`: exception wins; the interrupt is retaken after return if still pending.
- Simultaneous `mret_wb` and `exc_illegal`: exception wins.

## Structure
- Package `trap_pkg`:
  - CSR addresses MSTATUS=12'h300, MTVEC=12'h305, MEPC=12'h341, MCAUSE=12'h342, MTVAL=12'h343.
  - Cause constants.
  - WSC_WRITE=2'b01.
  - State enum.
- Sub-module `trap_prio_enc` (combinational): inputs are the exception flags, `ext_irq`, MIE and instruction/address; outputs are `take_trap`, `cause[31:0]` and `tval[31:0]`.
- Top level holds the FSM, the capture registers and the output decode.

## Test plan
- Illegal instruction: inject `exc_illegal`, pc_wb=0x100, inst_wb=0xFFFFFFFF, mtvec=0x800.
  - T+1: writes 0x341←0x100 and 0x342←2, `trap_begin`.
  - T+2: writes 0x343←0xFFFFFFFF, redirect_pc=0x800.
- Load fault with addr_wb=0x2003 and ecall set in the same cycle: mcause=11, mtval=0.
- External interrupt with mstatus=0x88: mcause=0x8000000B, mepc=pc_wb. The same interrupt with mstatus=0x80 is ignored and `flush` stays 0.
- `mret` with mepc=0x104: T+1 `trap_end`=1, redirect_pc=0x104. Back in IDLE at T+2.
- Hold `exc_ecall` through TRAP_W and TRAP_TV: exactly one trap sequence is issued, and it repeats only after IDLE.
- Assert `rst` during TRAP_W: all outputs 0 the same cycle; no `trap_begin` after reset release.
